// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared types for the multi-channel UART transmit arbiter
package uart_tx_arbiter_pkg;

  localparam int UART_DATA_W = 8;
  localparam int MAX_CH      = 8;

  typedef logic [UART_DATA_W-1:0] uart_data_t;

  typedef struct packed {
    logic       last;
    uart_data_t data;
  } arb_entry_t;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_START,
    ARB_SETTLE,
    ARB_WAIT_DONE,
    ARB_HOLD
  } arb_state_t;

  typedef logic [$clog2(MAX_CH)-1:0] chan_id_t;

  function automatic int unsigned rr_next(input int unsigned ch, input int unsigned n);
    return (ch + 1 >= n) ? 0 : ch + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_chan_fifo.sv
// rtl/uart_tx_arbiter_chan_fifo.sv - show-ahead per-channel FIFO holding {last,data} entries
module uart_tx_chan_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [DATA_W:0] wr_entry,
  input  logic            rd_en,
  output logic [DATA_W:0] head,
  output logic            empty,
  output logic            full,
  output logic            overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic            do_wr, do_rd;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign do_rd    = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign do_wr    = wr_en && (!full || do_rd);
  assign head     = mem_q[rd_ptr_q];
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_wr && !do_rd)      count_q <= count_q + CW'(1);
      else if (!do_wr && do_rd) count_q <= count_q - CW'(1);
      if (wr_en && !do_wr) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin merge of per-channel byte FIFOs into one UART transmitter
// Packets stay atomic on the granted channel until the byte flagged last is sent or the hold times out.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DEPTH        = 16,
  parameter int DATA_W       = 8,
  parameter int HOLD_TIMEOUT = 1024,
  localparam int GW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        wr_en,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic [NUM_CH-1:0]        wr_last,
  output logic [NUM_CH-1:0]        ch_full,
  output logic [NUM_CH-1:0]        ch_overflow,
  output logic [NUM_CH-1:0]        ch_timeout,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_busy,
  output logic                     grant_valid,
  output logic [GW-1:0]            grant_ch
);

  localparam int TW = $clog2(HOLD_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX   = TW'(HOLD_TIMEOUT - 1);
  localparam logic [GW:0]   NCH_W  = (GW+1)'(NUM_CH);

  arb_state_t          state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d, rr_q, rr_d, pick_ch;
  logic                grant_valid_q, grant_valid_d, last_q, last_d;
  logic                tx_start_q, tx_start_d, pick_found;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NUM_CH-1:0]   timeout_q, timeout_d, empty_w, pop_w;
  logic [DATA_W:0]     head_w [NUM_CH];
  logic [DATA_W:0]     gnt_head_w;
  logic [2*NUM_CH-1:0] rot_w;
  logic [GW:0]         sum_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    uart_tx_chan_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[i]),
      .wr_entry ({wr_last[i], wr_data[i*DATA_W +: DATA_W]}),
      .rd_en    (pop_w[i]),
      .head     (head_w[i]),
      .empty    (empty_w[i]),
      .full     (ch_full[i]),
      .overflow (ch_overflow[i])
    );
  end

  assign gnt_head_w = head_w[grant_q];
  // Rotate the non-empty mask so bit j corresponds to channel rr+j.
  assign rot_w = {~empty_w, ~empty_w} >> rr_q;

  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    sum_w      = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (rot_w[j]) begin
        pick_found = 1'b1;
        sum_w      = {1'b0, rr_q} + (GW+1)'(j);
        pick_ch    = (sum_w >= NCH_W) ? GW'(sum_w - NCH_W) : GW'(sum_w);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    rr_d          = rr_q;
    timer_d       = timer_q;
    last_d        = last_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    timeout_d     = timeout_q;
    pop_w         = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (!tx_busy && pick_found) begin
          grant_d       = pick_ch;
          grant_valid_d = 1'b1;
          state_d       = ARB_START;
        end
      end
      ARB_START: begin
        tx_start_d = 1'b1;
        tx_data_d  = gnt_head_w[DATA_W-1:0];
        last_d     = gnt_head_w[DATA_W];
        pop_w      = NUM_CH'(1) << grant_q;
        state_d    = ARB_SETTLE;
      end
      // The transmitter raises busy one cycle after start, so busy is not trusted here.
      ARB_SETTLE: state_d = ARB_WAIT_DONE;
      ARB_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_valid_d = 1'b0;
            rr_d          = GW'(rr_next(32'(grant_q), NUM_CH));
            state_d       = ARB_IDLE;
          end else if (!empty_w[grant_q]) begin
            state_d = ARB_START;
          end else begin
            timer_d = '0;
            state_d = ARB_HOLD;
          end
        end
      end
      ARB_HOLD: begin
        if (!empty_w[grant_q]) begin
          state_d = ARB_START;
        end else if (timer_q == TMAX) begin
          timeout_d     = timeout_q | (NUM_CH'(1) << grant_q);
          grant_valid_d = 1'b0;
          rr_d          = GW'(rr_next(32'(grant_q), NUM_CH));
          state_d       = ARB_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      rr_q          <= '0;
      timer_q       <= '0;
      last_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      rr_q          <= rr_d;
      timer_q       <= timer_d;
      last_q        <= last_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      timeout_q     <= timeout_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_valid = grant_valid_q;
  assign grant_ch    = grant_q;
  assign ch_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int HT     = 8;
  localparam int FRAME  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wr_en, wr_last;
  logic [31:0] wr_data;
  logic [3:0]  ch_full, ch_overflow, ch_timeout;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        grant_valid;
  logic [1:0]  grant_ch;
  logic        busy_stuck;
  int          busy_cnt = 0;
  int          checks   = 0;
  int          failures = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  obs_q[$];

  uart_tx_arbiter #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .HOLD_TIMEOUT(HT)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .ch_full     (ch_full),
    .ch_overflow (ch_overflow),
    .ch_timeout  (ch_timeout),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_valid (grant_valid),
    .grant_ch    (grant_ch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tx_start === 1'b1)  busy_cnt <= FRAME;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = busy_stuck || (busy_cnt != 0);

  always @(negedge clk) begin
    if (tx_start === 1'b1) obs_q.push_back({grant_ch, tx_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = '0; wr_last = '0; wr_data = '0; busy_stuck = 1'b0;
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic wr4(input logic [3:0] en, input logic [31:0] data, input logic [3:0] last);
    wr_en = en; wr_data = data; wr_last = last;
    tick();
    wr_en = '0;
  endtask

  task automatic write1(input int ch, input logic [7:0] d, input logic last);
    logic [31:0] data;
    data = '0;
    data[ch*8 +: 8] = d;
    wr4(4'(1 << ch), data, 4'(last) << ch);
  endtask

  task automatic expect_byte(input int ch, input logic [7:0] d);
    exp_q.push_back({2'(ch), d});
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_tx_start"}, 32'(tx_start), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_grant_valid"}, 32'(grant_valid), 0);
    chk({tag, "_grant_ch"}, 32'(grant_ch), 0);
    chk({tag, "_flags"}, 32'({ch_full, ch_overflow, ch_timeout}), 0);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < budget) begin tick(); n++; end
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_byte"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    n = 0;
    while ((grant_valid || tx_busy) && n < budget) begin tick(); n++; end
    chk({tag, "_idle"}, 32'({grant_valid, tx_busy}), 0);
    obs_q.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; wr_en = '0; wr_last = '0; wr_data = '0; busy_stuck = 1'b0;
    do_reset();
    chk_quiet("reset");

    // 1: single byte on ch2, start two cycles after the write edge
    write1(2, 8'h41, 1'b1);
    expect_byte(2, 8'h41);
    chk("t1_lat0", 32'(tx_start), 0);
    tick();
    chk("t1_lat1", 32'(tx_start), 0);
    chk("t1_gv", 32'(grant_valid), 1);
    chk("t1_gch", 32'(grant_ch), 2);
    tick();
    chk("t1_lat2", 32'(tx_start), 1);
    chk("t1_data", 32'(tx_data), 32'h41);
    n = 0;
    while (grant_valid && n < 60) begin tick(); n++; end
    chk("t1_release", 32'({grant_valid, tx_busy}), 0);
    drain("t1", 60);

    // 2: three-byte packet on ch0 is not interleaved with ch1
    wr4(4'b0011, {16'h0, 8'h61, 8'h1B}, 4'b0010);
    wr4(4'b0001, {24'h0, 8'h5B}, 4'b0000);
    wr4(4'b0001, {24'h0, 8'h41}, 4'b0001);
    expect_byte(0, 8'h1B); expect_byte(0, 8'h5B); expect_byte(0, 8'h41); expect_byte(1, 8'h61);
    drain("t2", 200);

    // 3: round robin from rr=0, twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      wr4(4'hF, 32'hDDCCBBAA, 4'hF);
      expect_byte(0, 8'hAA); expect_byte(1, 8'hBB); expect_byte(2, 8'hCC); expect_byte(3, 8'hDD);
      drain("t3", 200);
    end

    // 4: fill ch3 while the transmitter is stuck busy
    busy_stuck = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      write1(3, 8'(8'h30 + i), 1'b1);
      if (i < DEPTH) expect_byte(3, 8'(8'h30 + i));
      if (i == DEPTH - 2) chk("t4_not_full", 32'(ch_full[3]), 0);
      if (i == DEPTH - 1) begin
        chk("t4_full", 32'(ch_full[3]), 1);
        chk("t4_no_ovf", 32'(ch_overflow[3]), 0);
      end
    end
    chk("t4_ovf", 32'(ch_overflow), 32'h8);
    chk("t4_no_tx", 32'(obs_q.size()), 0);
    busy_stuck = 1'b0;
    drain("t4", 500);
    chk("t4_ovf_sticky", 32'({ch_full[3], ch_overflow[3]}), 1);

    // 5: incomplete packet on ch1 times out; ch0 goes next
    write1(1, 8'h1B, 1'b0);
    expect_byte(1, 8'h1B);
    n = 0;
    while (tx_start !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("t5_started", 32'(tx_start), 1);
    write1(0, 8'h30, 1'b1);
    expect_byte(0, 8'h30);
    tick(FRAME + 8);
    chk("t5_pre_timeout", 32'(ch_timeout), 0);
    chk("t5_holding", 32'({grant_valid, grant_ch}), 32'b101);
    tick();
    chk("t5_timeout", 32'(ch_timeout), 32'h2);
    chk("t5_release", 32'(grant_valid), 0);
    drain("t5", 200);

    // 6: reset during WAIT_DONE with three bytes still queued
    wr4(4'b0100, 32'h00100000, 4'b0000);
    wr4(4'b0100, 32'h00110000, 4'b0000);
    wr4(4'b0100, 32'h00120000, 4'b0000);
    wr4(4'b0100, 32'h00130000, 4'b0100);
    tick(4);
    chk("t6_first_sent", 32'(obs_q.size()), 1);
    rst = 1'b1;
    tick();
    chk_quiet("t6_rst");
    rst = 1'b0;
    obs_q.delete();
    tick(40);
    chk("t6_no_tx", 32'(obs_q.size()), 0);
    write1(2, 8'h77, 1'b1);
    expect_byte(2, 8'h77);
    drain("t6", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
